// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, status flag bundle
// and operation encodings.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cla_adder.sv
// Two-level carry-lookahead adder: 4-bit generate/propagate blocks plus
// a lookahead across blocks. Exposes the carry into the MSB for overflow.
module cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    localparam int NB = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NB-1:0]    blk_g;
    logic [NB-1:0]    blk_p;
    logic [NB:0]      blk_c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            blk_g[i] = g[4*i+3]
                     | (p[4*i+3] & g[4*i+2])
                     | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            blk_p[i] = &p[4*i +: 4];
        end
    end

    // Each block carry is a flat sum of products, not a ripple chain
    always_comb begin
        logic pp;
        blk_c    = '0;
        blk_c[0] = cin;
        for (int i = 1; i <= NB; i++) begin
            for (int k = 0; k < i; k++) begin
                pp = 1'b1;
                for (int m = k + 1; m < i; m++) begin
                    pp = pp & blk_p[m];
                end
                blk_c[i] = blk_c[i] | (blk_g[k] & pp);
            end
            pp = 1'b1;
            for (int m = 0; m < i; m++) begin
                pp = pp & blk_p[m];
            end
            blk_c[i] = blk_c[i] | (pp & cin);
        end
    end

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            c[4*i]   = blk_c[i];
            c[4*i+1] = g[4*i] | (p[4*i] & blk_c[i]);
            c[4*i+2] = g[4*i+1]
                     | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & blk_c[i]);
            c[4*i+3] = g[4*i+2]
                     | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & blk_c[i]);
        end
    end

    assign sum      = p ^ c;
    assign cout     = blk_c[NB];
    assign c_msb_in = c[WIDTH-1];

endmodule

// File: rtl/add_sub.sv
// Two's-complement adder/subtractor: combinational result plus a
// one-cycle registered copy with NZCV flags.
module add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             is_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             out_valid
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             c_msb_in;
    flags_t           flags;
    flags_t           flags_q;

    // Subtract is a + ~b + 1 through the same adder
    assign b_eff = b ^ {WIDTH{is_sub == OP_SUB}};

    cla_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a        (a),
        .b        (b_eff),
        .cin      (is_sub),
        .sum      (sum),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    assign out     = sum;
    assign flags.n = sum[WIDTH-1];
    assign flags.z = (sum == '0);
    assign flags.c = cout;
    assign flags.v = cout ^ c_msb_in;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q     <= '0;
            flags_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q   <= sum;
                flags_q <= flags;
            end
        end
    end

    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_add_sub.sv
// Directed-vector and random self-checking bench for add_sub at WIDTH 32.
module tb_add_sub;

    localparam int W = 32;

    logic         CLK;
    logic         RST_N;
    logic         is_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    add_sub #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .is_sub    (is_sub),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .out_valid (out_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [3:0]   nzcv;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] nzcv();
        return {flag_n, flag_z, flag_c, flag_v};
    endfunction

    task automatic capture(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic vs);
        @(negedge CLK);
        a = va;
        b = vb;
        is_sub = vs;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    logic [W-1:0] hq;
    logic [3:0]   hf;
    logic [W:0]   r;
    logic signed [W+1:0] sr;
    logic [W-1:0] eo;
    logic [3:0]   ef;

    initial begin
        vecs[0] = '{32'd312, 32'd1000, 1'b0, 32'd1312, 4'b0000};
        vecs[1] = '{32'd312, 32'd1000, 1'b1, 32'hFFFFFD50, 4'b1000};
        vecs[2] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 4'b0110};
        vecs[3] = '{32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 4'b1001};
        vecs[4] = '{32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 4'b0011};
        vecs[5] = '{32'd5, 32'd5, 1'b1, 32'h0, 4'b0110};

        RST_N = 1'b0;
        in_valid = 1'b0;
        is_sub = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("reset out_q", out_q, 0);
        chk("reset flags", nzcv(), 0);
        chk("reset out_valid", out_valid, 0);

        a = 312;
        b = 1000;
        is_sub = 0;
        #1;
        chk("comb add", out, 32'd1312);
        is_sub = 1;
        #1;
        chk("comb sub", out, 32'hFFFFFD50);

        @(negedge CLK);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            capture(vecs[i].a, vecs[i].b, vecs[i].s);
            chk($sformatf("vec%0d out_q", i), out_q, vecs[i].q);
            chk($sformatf("vec%0d nzcv", i), nzcv(), vecs[i].nzcv);
            chk($sformatf("vec%0d valid", i), out_valid, 1);
        end

        // Back-to-back captures then a hold cycle
        capture(32'd10, 32'd3, 1'b1);
        chk("b2b0 out_q", out_q, 32'd7);
        capture(32'd3, 32'd10, 1'b1);
        chk("b2b1 out_q", out_q, 32'hFFFFFFF9);
        chk("b2b1 nzcv", nzcv(), 4'b1000);
        capture(32'd100, 32'd23, 1'b0);
        chk("b2b2 out_q", out_q, 32'd123);
        chk("b2b2 valid", out_valid, 1);
        hq = out_q;
        hf = nzcv();
        @(negedge CLK);
        in_valid = 1'b0;
        a = 32'hDEAD;
        b = 32'hBEEF;
        @(posedge CLK);
        #1;
        chk("hold out_q", out_q, hq);
        chk("hold flags", nzcv(), hf);
        chk("hold valid", out_valid, 0);
        @(posedge CLK);
        #1;
        chk("hold2 out_q", out_q, hq);

        // Asynchronous reset mid-cycle after a capture
        capture(32'hFFFFFFFF, 32'd1, 1'b0);
        chk("pre-rst valid", out_valid, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async rst out_q", out_q, 0);
        chk("async rst flags", nzcv(), 0);
        chk("async rst valid", out_valid, 0);
        a = 32'd40;
        b = 32'd2;
        is_sub = 1'b1;
        #1;
        chk("rst comb out", out, 32'd38);
        @(posedge CLK);
        #1;
        chk("rst discard valid", out_valid, 0);
        chk("rst discard out_q", out_q, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post-rst out_q", out_q, 32'd38);
        chk("post-rst valid", out_valid, 1);

        for (int i = 0; i < 10000; i++) begin
            @(negedge CLK);
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = a;
            is_sub = 1'($urandom);
            in_valid = 1'b1;
            if (is_sub) r = {1'b0, a} + {1'b0, ~b} + 1;
            else        r = {1'b0, a} + {1'b0, b};
            if (is_sub) sr = $signed(a) - $signed(b);
            else        sr = $signed(a) + $signed(b);
            eo = r[W-1:0];
            ef[3] = eo[W-1];
            ef[2] = (eo == 0);
            ef[1] = r[W];
            ef[0] = (sr > 34'sh7FFFFFFF) || (sr < -34'sh80000000);
            #1;
            chk("rand out", out, eo);
            @(posedge CLK);
            #1;
            chk("rand out_q", out_q, eo);
            chk("rand nzcv", nzcv(), ef);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
